// File: rtl/file_page_table.sv
// File page table: records BIOS-generated file extents and translates (id, offset) into HD addresses.
// Optional bounds checking on translation is enabled by defining PAGE_TABLE_BOUNDS_CHECK_EN.
module file_page_table #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            save_page,
  input  logic [31:0]     page,
  input  logic            clear,
  input  logic            req_valid,
  input  logic [ID_W-1:0] req_id,
  input  logic [15:0]     req_offset,
  output logic            rsp_valid,
  output logic [15:0]     rsp_addr,
  output logic            rsp_fault,
  output logic [ID_W:0]   count,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            bad_page
);

  localparam logic [ID_W:0] DEPTH_C = (ID_W + 1)'(DEPTH);

  logic [15:0]     base_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [ID_W-1:0] wr_ptr;

  logic [15:0] page_begin;
  logic [15:0] page_end;
  logic        save_live;
  logic        commit;
  logic        reject_bad;
  logic        reject_full;
  logic        hit;
  logic [15:0] addr_next;
  logic        fault_next;

  assign page_begin = page[31:16];
  assign page_end   = page[15:0];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // clear wins over save_page; a full table rejects before the begin/end check is consulted
  assign save_live   = save_page && !clear;
  assign reject_full = save_live && full;
  assign commit      = save_live && !full && (page_begin <= page_end);
  assign reject_bad  = save_live && !full && (page_begin > page_end);

  assign hit = valid_q[req_id];

`ifdef PAGE_TABLE_BOUNDS_CHECK_EN
  // End addresses are only consulted by the bounds check, so they are stored only in this build.
  logic [15:0] end_q [DEPTH];
  logic [16:0] sum;
  logic        out_of_bounds;

  always_ff @(posedge clk) begin
    if (commit) end_q[wr_ptr] <= page_end;
  end

  assign sum           = 17'(base_q[req_id]) + 17'(req_offset);
  assign out_of_bounds = sum[16] || (sum[15:0] > end_q[req_id]);
  assign fault_next    = !hit || out_of_bounds;
  assign addr_next     = hit ? sum[15:0] : 16'h0000;
`else
  logic [15:0] sum;

  assign sum        = base_q[req_id] + req_offset;
  assign fault_next = !hit;
  assign addr_next  = hit ? sum : 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (commit) base_q[wr_ptr] <= page_begin;
  end

  // req/rsp: no backpressure; every req_valid cycle is accepted and answered by exactly one
  // rsp_valid pulse on the following cycle, computed from the table as it stood before that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bad_page  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= req_valid;
      rsp_addr  <= req_valid ? addr_next : 16'h0000;
      rsp_fault <= req_valid && fault_next;
      bad_page  <= reject_bad;
      if (clear) begin
        valid_q  <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (commit) begin
          valid_q[wr_ptr] <= 1'b1;
          wr_ptr          <= wr_ptr + ID_W'(1);
          count           <= count + (ID_W + 1)'(1);
        end
        if (reject_full) overflow <= 1'b1;
      end
    end
  end

endmodule
